// File: rtl/scope_pkg.sv
// Shared types and sizes for the oscilloscope capture path.
package scope_pkg;

    localparam int ADC_W  = 12;
    localparam int ADDR_W = 10;
    localparam int TB_MAX = 7;
    localparam int TB_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    // Number of valid samples between stored samples for a decimation exponent.
    function automatic logic [7:0] dec_period(input logic [TB_W-1:0] tb);
        return 8'd1 << tb;
    endfunction

endpackage

// File: rtl/timebase_sel.sv
// Up/down selector for the decimation exponent, saturating at 0 and TB_MAX.
module timebase_sel
    import scope_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            button_u,
    input  logic            button_d,
    output logic [TB_W-1:0] timebase
);

    logic [TB_W-1:0] tb_reg;
    logic [TB_W-1:0] tb_next;

    always_comb begin
        tb_next = tb_reg;
        if (button_u && !button_d && tb_reg != TB_W'(TB_MAX)) begin
            tb_next = tb_reg + TB_W'(1);
        end else if (button_d && !button_u && tb_reg != '0) begin
            tb_next = tb_reg - TB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tb_reg <= '0;
        end else begin
            tb_reg <= tb_next;
        end
    end

    assign timebase = tb_reg;

endmodule

// File: rtl/capture_ctrl.sv
// Trigger/capture sequencer: drives the ADC, finds a rising-edge trigger and
// streams one decimated frame into the sample buffer for the display.
module capture_ctrl
    import scope_pkg::*;
#(
    parameter int DEPTH        = 640,
    parameter int AUTO_TIMEOUT = 4096
)(
    input  logic              CLK,
    input  logic              reset,
    input  logic              run,
    input  logic              button_u,
    input  logic              button_d,
    input  logic [ADC_W-1:0]  trig_level,
    output logic              adc_start,
    input  logic              adc_busy,
    input  logic              adc_valid,
    input  logic [ADC_W-1:0]  adc_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADC_W-1:0]  wr_data,
    output logic              frame_ready,
    input  logic              frame_ack,
    output logic [TB_W-1:0]   timebase
);

    localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);

    state_t            state_reg, state_next;
    logic [TB_W-1:0]   tb_latched_reg;
    logic [TO_W-1:0]   to_cnt_reg;
    logic [7:0]        dec_cnt_reg;
    logic [ADC_W-1:0]  prev_reg;
    logic              prev_valid_reg;
    logic              outstanding_reg;
    logic              adc_start_reg;
    logic              wr_en_reg;
    logic              frame_ready_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [ADC_W-1:0]  wr_data_reg;

    logic sample, arm_entry, trigger, cap_write, issue, dec_hit;

    timebase_sel u_timebase_sel (
        .clk      (CLK),
        .reset    (reset),
        .button_u (button_u),
        .button_d (button_d),
        .timebase (timebase)
    );

    always_comb begin
        state_next = state_reg;
        arm_entry  = 1'b0;
        trigger    = 1'b0;
        cap_write  = 1'b0;
        sample     = adc_valid && run;
        dec_hit    = (dec_cnt_reg + 8'd1) == dec_period(tb_latched_reg);
        if (!run) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_ARM;
                    arm_entry  = 1'b1;
                end
                ST_ARM: begin
                    if (adc_valid) begin
                        // The auto-timeout fires on the AUTO_TIMEOUT-th sample itself.
                        trigger = (prev_valid_reg && prev_reg < trig_level
                                   && adc_data >= trig_level)
                               || (to_cnt_reg == TO_W'(AUTO_TIMEOUT - 1));
                        if (trigger) begin
                            state_next = (DEPTH == 1) ? ST_HOLD : ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (adc_valid && dec_hit) begin
                        cap_write = 1'b1;
                        if (wr_addr_reg == ADDR_W'(DEPTH - 2)) begin
                            state_next = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (frame_ack) begin
                        state_next = ST_ARM;
                        arm_entry  = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
        // A conversion finishing this cycle frees the ADC for a back-to-back start.
        issue = run && (state_reg == ST_ARM || state_reg == ST_CAPTURE)
             && state_next != ST_HOLD && !adc_busy
             && (!outstanding_reg || adc_valid);
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            adc_start_reg   <= 1'b0;
            wr_en_reg       <= 1'b0;
            frame_ready_reg <= 1'b0;
            outstanding_reg <= 1'b0;
            tb_latched_reg  <= '0;
            to_cnt_reg      <= '0;
            dec_cnt_reg     <= '0;
            prev_reg        <= '0;
            prev_valid_reg  <= 1'b0;
            wr_addr_reg     <= '0;
            wr_data_reg     <= '0;
        end else begin
            adc_start_reg   <= issue;
            wr_en_reg       <= trigger || cap_write;
            frame_ready_reg <= (state_next == ST_HOLD);
            if (issue) begin
                outstanding_reg <= 1'b1;
            end else if (adc_valid) begin
                outstanding_reg <= 1'b0;
            end
            if (arm_entry) begin
                tb_latched_reg <= timebase;
                to_cnt_reg     <= '0;
                prev_valid_reg <= 1'b0;
            end else if (state_reg == ST_ARM && sample) begin
                prev_reg       <= adc_data;
                prev_valid_reg <= 1'b1;
                to_cnt_reg     <= to_cnt_reg + TO_W'(1);
            end
            if (trigger) begin
                wr_addr_reg <= '0;
                wr_data_reg <= adc_data;
                dec_cnt_reg <= '0;
            end else if (state_reg == ST_CAPTURE && sample) begin
                dec_cnt_reg <= dec_hit ? 8'd0 : dec_cnt_reg + 8'd1;
                if (dec_hit) begin
                    wr_addr_reg <= wr_addr_reg + ADDR_W'(1);
                    wr_data_reg <= adc_data;
                end
            end
        end
    end

    assign adc_start   = adc_start_reg;
    assign wr_en       = wr_en_reg;
    assign wr_addr     = wr_addr_reg;
    assign wr_data     = wr_data_reg;
    assign frame_ready = frame_ready_reg;

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 640: samples per captured frame, one per VGA column.
REQ-002 SHALL have parameter AUTO_TIMEOUT, default 4096: valid samples in ARM without a trigger before a forced capture.
REQ-003 SHALL have port CLK, input, 1: system clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port run, input, 1: 1 = acquisition enabled.
REQ-006 SHALL have ports button_u and button_d, inputs, 1 each: debounced single-cycle pulses.
REQ-007 SHALL have port trig_level, input, 12: rising-edge trigger threshold, unsigned.
REQ-008 SHALL have ports adc_start (output, 1), adc_busy (input, 1), adc_valid (input, 1) and adc_data (input, 12): the handshake to the serial ADC interface.
REQ-009 SHALL have ports wr_en (output, 1), wr_addr (output, 10) and wr_data (output, 12): the sample-buffer write port.
REQ-010 SHALL have ports frame_ready (output, 1) and frame_ack (input, 1): the handshake with the display reader.
REQ-011 SHALL have port timebase, output, 3: current decimation exponent.

Function
REQ-012 SHALL implement the states IDLE, ARM, CAPTURE and HOLD.
REQ-013 SHALL go from IDLE to ARM when run=1; from any state to IDLE within 1 cycle when run=0, abandoning the frame and clearing frame_ready.
REQ-014 SHALL pulse adc_start for 1 cycle whenever the state is ARM or CAPTURE, adc_busy=0 and no conversion is outstanding; a conversion is outstanding from adc_start until adc_valid.
REQ-015 SHALL, in ARM, treat the first valid sample after entry only as the previous sample (prev), with no trigger test.
REQ-016 SHALL detect a trigger on a valid sample when prev < trig_level and adc_data >= trig_level; prev then updates on every valid sample.
REQ-017 SHALL count valid samples in ARM and, when the count reaches AUTO_TIMEOUT, force a trigger on that sample.
REQ-018 SHALL, on a trigger (real or forced), write that sample at wr_addr=0, clear the decimation counter and enter CAPTURE.
REQ-019 SHALL, in CAPTURE, write every 2^tb_latched-th valid sample at consecutive addresses; wr_en is high 1 cycle, 1 cycle after adc_valid.
REQ-020 SHALL enter HOLD after the write to address DEPTH-1; wr_addr never exceeds DEPTH-1.
REQ-021 SHALL, in HOLD, hold frame_ready=1 and issue no adc_start; when frame_ack=1, clear frame_ready and go to ARM on the next cycle.
REQ-022 SHALL ignore frame_ack outside HOLD.
REQ-023 SHALL increment timebase on button_u, saturating at 7, and decrement it on button_d, saturating at 0; simultaneous pulses leave it unchanged.
REQ-024 SHALL change timebase in any state, and SHALL copy it into tb_latched only on ARM entry, so a frame in progress keeps its rate.

Reset
REQ-025 SHALL, while reset=0, force state=IDLE, adc_start=0, wr_en=0, wr_addr=0, wr_data=0, frame_ready=0, timebase=0, all counters=0 and prev-valid=0.
REQ-026 SHALL, on an assertion of reset mid-CAPTURE, abort the frame with no further writes.

Structure
REQ-027 SHALL take the state encoding, ADC_W=12, ADDR_W=10 and TB_MAX=7 from a shared package, scope_pkg.
REQ-028 SHALL implement the button/saturation logic as one sub-module, timebase_sel.
REQ-029 SHALL hold the FSM, ADC sequencing and address counters in capture_ctrl itself.

Verification
REQ-030 SHALL verify a ramp: run=1, trig_level=2048, ADC ramp 2040..2060 -> trigger on 2048, wr_addr=0 data=2048, 640 writes, then frame_ready=1.
REQ-031 SHALL verify decimation: timebase=2 (two button_u pulses before ARM) -> written samples are inputs 0, 4, 8, ... after the trigger, last write at addr 639.
REQ-032 SHALL verify auto-trigger: constant ADC value 1000, trig_level=2048 -> forced capture after exactly 4096 valid samples in ARM.
REQ-033 SHALL verify the display handshake: frame_ack held 0 for 10,000 cycles -> frame_ready stays 1, no adc_start, no wr_en; frame_ack=1 -> ARM next cycle.
REQ-034 SHALL verify the buttons: simultaneous button_u/button_d -> timebase unchanged; eight button_u pulses from 0 -> 7; button_d at 0 -> 0.
REQ-035 SHALL verify aborts: run=0 at wr_addr=300 -> IDLE within 1 cycle, no further writes; reset=0 mid-CAPTURE -> every output at its REQ-025 reset value.
